cla4_serial_add_ctrl: RTL and testbench

- Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit carry look-ahead adder, one nibble per cycle, LSB nibble first.
- The inter-nibble carry is held in a register.
- Valid/ready handshake on both input and output sides.
- Sits between the operand source and any consumer that wants wide sums without a wide adder.

---
 rtl/cla4_serial_add_ctrl_pkg.sv | 12 +
 rtl/cla4_serial_add_ctrl_adder.sv | 32 +++
 rtl/cla4_serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_cla4_serial_add_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla4_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial carry look-ahead add/subtract sequencer.
package cla4_serial_add_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla4_serial_add_ctrl_adder.sv
// 4-bit carry look-ahead adder; exposes the per-bit carry-in vector so the
// controller can see the carry into the MSB of the nibble.
module carry_lookahead_adder4
  import cla4_serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic [NIBBLE_W-1:0] carry
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;

  assign g = a & b;
  assign p = a ^ b;

  // carry[i] is the carry into bit i, each expanded directly from cin.
  assign carry[0] = cin;
  assign carry[1] = g[0] | (p[0] & cin);
  assign carry[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign carry[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & cin);
  assign cout     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ carry;

endmodule

// File: rtl/cla4_serial_add_ctrl.sv
// WIDTH-bit add/subtract built from one 4-bit CLA used once per nibble, LSB
// nibble first, with the inter-nibble carry held in carry_r.
module cla4_serial_add_ctrl
  import cla4_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = $clog2(NIB);

  state_t state;
  state_t state_nx;

  logic [IDX_W-1:0]                idx;
  logic                            carry_r;
  logic [NIB-1:0][NIBBLE_W-1:0]    a_r;
  logic [NIB-1:0][NIBBLE_W-1:0]    b_r;
  logic [NIB-1:0][NIBBLE_W-1:0]    sum_r;

  logic [NIBBLE_W-1:0] add_sum;
  logic                add_cout;
  logic [NIBBLE_W-1:0] add_carry;
  logic                last;
  logic                unused_carry;

  carry_lookahead_adder4 u_adder (
    .a     (a_r[idx]),
    .b     (b_r[idx]),
    .cin   (carry_r),
    .sum   (add_sum),
    .cout  (add_cout),
    .carry (add_carry)
  );

  assign last         = (idx == IDX_W'(NIB - 1));
  assign sum          = sum_r;
  assign unused_carry = ^add_carry[2:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: a_r/b_r carry no reset: they are always loaded at accept before
  // RUN reads them, so resetting them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      carry_r  <= 1'b0;
      sum_r    <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            idx     <= '0;
            sum_r   <= '0;
          end
        end
        RUN: begin
          sum_r[idx] <= add_sum;
          carry_r    <= add_cout;
          if (last) begin
            idx      <= '0;
            cout     <= add_cout;
            overflow <= add_carry[3] ^ add_cout;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla4_serial_add_ctrl.sv
// Self-checking bench: directed corner cases plus random ops checked against
// a plain-arithmetic reference model.
module tb_cla4_serial_add_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;

  int checks = 0;
  int errors = 0;

  cla4_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned arithmetic for sum/carry, sign rules for overflow.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic mcin, input logic msub,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    logic [W:0] full;
    if (msub) begin
      full = {1'b0, ma} - {1'b0, mb};
      es   = full[W-1:0];
      ec   = (ma >= mb);
      eo   = (ma[W-1] != mb[W-1]) && (es[W-1] != ma[W-1]);
    end else begin
      full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
      es   = full[W-1:0];
      ec   = full[W];
      eo   = (ma[W-1] == mb[W-1]) && (es[W-1] != ma[W-1]);
    end
  endtask

  // Accepts one op, checks latency and result, then releases after hold cycles.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input int hold);
    int cycles;
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready_before_accept got=%b exp=1", name, in_ready);
    end
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (out_valid !== 1'b1 && cycles < 20);
    checks++;
    if (cycles != NIB) begin
      errors++;
      $display("FAIL %s latency got=%0d exp=%0d", name, cycles, NIB);
      if (out_valid !== 1'b1) return;
    end
    checks++;
    if (sum !== es || cout !== ec || overflow !== eo) begin
      errors++;
      $display("FAIL %s result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
               name, sum, cout, overflow, es, ec, eo);
    end
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s release got in_ready=%b out_valid=%b exp 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset got rdy=%b vld=%b busy=%b sum=%h cout=%b ovf=%b",
               in_ready, out_valid, busy, sum, cout, overflow);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_op("add_basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    run_op("add_ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op("add_pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
    run_op("add_neg_ovf", 16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0);
    run_op("add_cin",     16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
    run_op("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    run_op("sub_noborrow",16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 2);
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, es;
    logic rc, rs, ec, eo;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      model(ra, rb, rc, rs, es, ec, eo);
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs, es, ec, eo, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_backpressure();
    int cycles;
    a = 16'hA5A5; b = 16'h1111; cin = 1'b1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (out_valid !== 1'b1 && cycles < 20);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout cycles=%0d", cycles);
      return;
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      tick();
      checks++;
      if (sum !== 16'hB6B7 || cout !== 1'b0 || overflow !== 1'b0 ||
          in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got sum=%h cout=%b ovf=%b rdy=%b vld=%b busy=%b",
                 i, sum, cout, overflow, in_ready, out_valid, busy);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'hB6B7) begin
      errors++;
      $display("FAIL bp_release got rdy=%b vld=%b sum=%h exp 1/0/b6b7", in_ready, out_valid, sum);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_accept got busy=%b rdy=%b exp 0/1", busy, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    a = 16'h1357; b = 16'h2468; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy got=%b exp=1", busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0) begin
      errors++;
      $display("FAIL midrun_reset got rdy=%b vld=%b busy=%b sum=%h exp 1/0/0/0000",
               in_ready, out_valid, busy, sum);
    end
    run_op("after_reset", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
